// File: rtl/sdram_req_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sdram_req_arbiter_if : requester-side and sdram_core-side bundle           |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface sdram_req_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int ADDR_W = 24,
  parameter int DATA_W = 32
);
  logic [NREQ-1:0]          req_valid;
  logic [NREQ-1:0]          req_ready;
  logic [NREQ-1:0]          req_we;
  logic [NREQ*ADDR_W-1:0]   req_addr;
  logic [NREQ*DATA_W-1:0]   req_wdata;
  logic [NREQ*DATA_W/8-1:0] req_wmask;
  logic [NREQ-1:0]          resp_valid;
  logic [DATA_W-1:0]        resp_rdata;

  logic                     mem_valid;
  logic                     mem_ready;
  logic                     mem_we;
  logic [ADDR_W-1:0]        mem_addr;
  logic [DATA_W-1:0]        mem_wdata;
  logic [DATA_W/8-1:0]      mem_wmask;
  logic                     mem_resp_valid;
  logic [DATA_W-1:0]        mem_rdata;

  // The arbiter itself
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wmask,
    input  mem_ready, mem_resp_valid, mem_rdata,
    output req_ready, resp_valid, resp_rdata,
    output mem_valid, mem_we, mem_addr, mem_wdata, mem_wmask
  );

  // Requesters plus sdram_core, seen from outside the arbiter
  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wmask,
    output mem_ready, mem_resp_valid, mem_rdata,
    input  req_ready, resp_valid, resp_rdata,
    input  mem_valid, mem_we, mem_addr, mem_wdata, mem_wmask
  );
endinterface
`default_nettype wire

// File: rtl/sdram_req_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sdram_req_arbiter : round-robin sharing of the sdram_core request port,    |
// | one transaction in flight. SDRAM_ARB_PRIO0_EN gives requester 0 priority.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module sdram_req_arbiter #(
  parameter int NREQ   = 4,
  parameter int ADDR_W = 24,
  parameter int DATA_W = 32
) (
  input  wire logic          clk,
  input  wire logic          rst,
  sdram_req_arbiter_if.slave bus,
  output logic               busy
);

  localparam int MASK_W = DATA_W / 8;
  localparam int IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NREQ - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t              state_q;
  logic [IDX_W-1:0]    last_q;
  logic [IDX_W-1:0]    owner_q;
  logic                mem_valid_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [MASK_W-1:0]   mem_wmask_q;
  logic [NREQ-1:0]     req_ready_q;
  logic [NREQ-1:0]     resp_valid_q;
  logic [DATA_W-1:0]   resp_rdata_q;
  logic                busy_q;

  logic [NREQ-1:0]     cand_d;
  logic                grant_found_d;
  logic [IDX_W-1:0]    grant_idx_d;
  logic                upd_last_d;
  logic [IDX_W-1:0]    scan_idx_d;
  int                  scan_pos_d;
  logic                sel_we_d;
  logic [ADDR_W-1:0]   sel_addr_d;
  logic [DATA_W-1:0]   sel_wdata_d;
  logic [MASK_W-1:0]   sel_wmask_d;

  // Winner search starts just after the last grant and wraps modulo NREQ.
  always_comb begin
    cand_d        = bus.req_valid;
    grant_found_d = 1'b0;
    grant_idx_d   = '0;
    upd_last_d    = 1'b1;
    scan_pos_d    = 0;
    scan_idx_d    = '0;
`ifdef SDRAM_ARB_PRIO0_EN
    cand_d[0]     = 1'b0;
`endif
    for (int k = 1; k <= NREQ; k++) begin
      scan_pos_d = int'(last_q) + k;
      if (scan_pos_d >= NREQ) begin
        scan_pos_d = scan_pos_d - NREQ;
      end
      scan_idx_d = IDX_W'(scan_pos_d);
      if (!grant_found_d && cand_d[scan_idx_d]) begin
        grant_found_d = 1'b1;
        grant_idx_d   = scan_idx_d;
      end
    end
`ifdef SDRAM_ARB_PRIO0_EN
    // Requester 0 pre-empts the rotation without moving the pointer.
    if (bus.req_valid[0]) begin
      grant_found_d = 1'b1;
      grant_idx_d   = '0;
      upd_last_d    = 1'b0;
    end
`endif
  end

  always_comb begin
    sel_we_d    = bus.req_we[grant_idx_d];
    sel_addr_d  = bus.req_addr[grant_idx_d*ADDR_W +: ADDR_W];
    sel_wdata_d = bus.req_wdata[grant_idx_d*DATA_W +: DATA_W];
    sel_wmask_d = bus.req_wmask[grant_idx_d*MASK_W +: MASK_W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_q       <= LAST_RST;
      owner_q      <= '0;
      mem_valid_q  <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wmask_q  <= '0;
      req_ready_q  <= '0;
      resp_valid_q <= '0;
      resp_rdata_q <= '0;
      busy_q       <= 1'b0;
    end else begin
      req_ready_q  <= '0;
      resp_valid_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (grant_found_d) begin
            owner_q     <= grant_idx_d;
            if (upd_last_d) begin
              last_q <= grant_idx_d;
            end
            mem_valid_q <= 1'b1;
            mem_we_q    <= sel_we_d;
            mem_addr_q  <= sel_addr_d;
            mem_wdata_q <= sel_wdata_d;
            mem_wmask_q <= sel_wmask_d;
            busy_q      <= 1'b1;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // A completion arriving here is not ours yet and is ignored.
          if (mem_valid_q && bus.mem_ready) begin
            mem_valid_q          <= 1'b0;
            req_ready_q[owner_q] <= 1'b1;
            state_q              <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.mem_resp_valid) begin
            resp_valid_q[owner_q] <= 1'b1;
            resp_rdata_q          <= bus.mem_rdata;
            busy_q                <= 1'b0;
            state_q               <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.mem_valid  = mem_valid_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.mem_wmask  = mem_wmask_q;
  assign busy           = busy_q;

  a_no_resp_with_accept : assert property (@(posedge clk) disable iff (rst)
    !(state_q == S_ISSUE && mem_valid_q && bus.mem_ready && bus.mem_resp_valid));

endmodule
`default_nettype wire

// File: tb/tb_sdram_req_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sdram_req_arbiter : directed and random checks of sdram_req_arbiter     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_sdram_req_arbiter;
  localparam int NREQ = 4, ADDR_W = 24, DATA_W = 32, MASK_W = 4;

  typedef struct { bit we; bit [23:0] addr; bit [31:0] data; bit [3:0] mask; } cmd_t;
  typedef struct { int owner; bit [31:0] data; } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  always #5 clk = ~clk;

  sdram_req_arbiter_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
  sdram_req_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy)
  );

  logic [NREQ-1:0]        drv_valid = '0, drv_we = '0;
  logic [NREQ*ADDR_W-1:0] drv_addr  = '0;
  logic [NREQ*DATA_W-1:0] drv_wdata = '0;
  logic [NREQ*MASK_W-1:0] drv_wmask = '0;
  logic                   core_ready = 1'b0, core_resp = 1'b0;
  logic [31:0]            core_rdata = '0;
  assign bus.req_valid = drv_valid;
  assign bus.req_we    = drv_we;
  assign bus.req_addr  = drv_addr;
  assign bus.req_wdata = drv_wdata;
  assign bus.req_wmask = drv_wmask;
  assign bus.mem_ready = core_ready;
  assign bus.mem_resp_valid = core_resp;
  assign bus.mem_rdata = core_rdata;

  cmd_t cmdq[NREQ][$];
  exp_t exp_q[$];
  int   grant_log[$];
  bit [31:0] rdata_log[$];
  bit [31:0] core_mem[bit [23:0]];
  bit [31:0] ref_mem[bit [23:0]];

  int n_checks = 0, n_err = 0;
  int m_state = 0, m_owner = 0, m_last = NREQ - 1, issue_hold = 0;
  int waitcnt[NREQ];
  bit core_busy = 0;
  int lat_cnt = 0, stall_left = 0, stall_cfg = 0, lat_cfg = 0, resp_fired = 0;
  cmd_t cap;
  bit [31:0] cap_rd;
  int w, obs;
  cmd_t c;
  exp_t e;

  task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic bit [31:0] merge(input bit [31:0] old, input bit [31:0] d, input bit [3:0] m);
    bit [31:0] r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic int exp_winner(input logic [NREQ-1:0] v, input int last);
    logic [NREQ-1:0] cv = v;
`ifdef SDRAM_ARB_PRIO0_EN
    if (v[0]) return 0;
    cv[0] = 1'b0;
`endif
    for (int k = 1; k <= NREQ; k++) if (cv[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  // Reference model, sdram_core model and requester drivers, all on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      m_state = 0; m_last = NREQ - 1; exp_q.delete(); core_ready = 1'b0;
      for (int i = 0; i < NREQ; i++) waitcnt[i] = 0;
    end else begin
      case (m_state)
        0: begin
          chk("resp_idle", bus.resp_valid, '0);
          chk("grant_latency", bus.mem_valid, |drv_valid);
          if (|drv_valid) begin
            w = exp_winner(drv_valid, m_last);
            c = cmdq[w][0];
            chk("grant_we", bus.mem_we, c.we);
            chk("grant_addr", bus.mem_addr, c.addr);
            chk("grant_wdata", bus.mem_wdata, c.data);
            chk("grant_wmask", bus.mem_wmask, c.mask);
`ifndef SDRAM_ARB_PRIO0_EN
            for (int i = 0; i < NREQ; i++) begin
              if (i == w) waitcnt[i] = 0;
              else if (drv_valid[i]) begin
                waitcnt[i]++;
                chk("fair_wait", waitcnt[i] <= NREQ - 1, 1);
              end else waitcnt[i] = 0;
            end
            m_last = w;
`else
            if (w != 0) m_last = w;
`endif
            e.owner = w;
            if (c.we) begin
              ref_mem[c.addr] = merge(ref_mem.exists(c.addr) ? ref_mem[c.addr] : 32'h0, c.data, c.mask);
              e.data = 32'h0;
            end else e.data = ref_mem.exists(c.addr) ? ref_mem[c.addr] : 32'h0;
            exp_q.push_back(e);
            m_owner = w; m_state = 1; issue_hold = 0;
          end
        end
        1: begin
          chk("resp_issue", bus.resp_valid, '0);
          if (core_ready) begin
            chk("accept_ready", bus.req_ready, NREQ'(1) << m_owner);
            chk("accept_mem_valid", bus.mem_valid, 0);
            obs = -1;
            for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) obs = i;
            grant_log.push_back(obs);
            m_state = 2;
          end else begin
            c = cmdq[m_owner][0];
            chk("hold_valid", bus.mem_valid, 1);
            chk("hold_addr", bus.mem_addr, c.addr);
            chk("hold_wdata", bus.mem_wdata, c.data);
            chk("hold_wmask", bus.mem_wmask, c.mask);
            chk("hold_ready", bus.req_ready, '0);
            issue_hold++;
          end
        end
        default: begin
          chk("wait_ready", bus.req_ready, '0);
          chk("wait_mem_valid", bus.mem_valid, 0);
          if (core_resp) begin
            e = exp_q.pop_front();
            chk("resp_owner", bus.resp_valid, NREQ'(1) << e.owner);
            chk("resp_rdata", bus.resp_rdata, e.data);
            rdata_log.push_back(bus.resp_rdata);
            m_state = 0;
          end else chk("resp_wait", bus.resp_valid, '0);
        end
      endcase
      chk("busy", busy, m_state != 0);

      core_resp = 1'b0;
      if (core_ready) begin
        core_ready = 1'b0; core_busy = 1'b1;
        lat_cnt = (lat_cfg < 0) ? int'($urandom_range(0, 3)) : lat_cfg;
        if (cap.we) begin
          core_mem[cap.addr] = merge(core_mem.exists(cap.addr) ? core_mem[cap.addr] : 32'h0, cap.data, cap.mask);
          cap_rd = 32'h0;
        end else cap_rd = core_mem.exists(cap.addr) ? core_mem[cap.addr] : 32'h0;
      end else if (core_busy) begin
        if (lat_cnt == 0) begin
          core_resp = 1'b1; core_rdata = cap_rd; core_busy = 1'b0; resp_fired++;
        end else lat_cnt--;
      end else if (bus.mem_valid) begin
        if (stall_left == 0) begin
          core_ready = 1'b1;
          cap.we = bus.mem_we; cap.addr = bus.mem_addr; cap.data = bus.mem_wdata; cap.mask = bus.mem_wmask;
        end else stall_left--;
      end else stall_left = (stall_cfg < 0) ? int'($urandom_range(0, 3)) : stall_cfg;
    end

    for (int i = 0; i < NREQ; i++) begin
      if (drv_valid[i] && bus.req_ready[i]) begin
        void'(cmdq[i].pop_front());
        drv_valid[i] = 1'b0;
      end
      if (!drv_valid[i] && cmdq[i].size() > 0) begin
        drv_valid[i] = 1'b1;
        drv_we[i] = cmdq[i][0].we;
        drv_addr[i*ADDR_W +: ADDR_W]  = cmdq[i][0].addr;
        drv_wdata[i*DATA_W +: DATA_W] = cmdq[i][0].data;
        drv_wmask[i*MASK_W +: MASK_W] = cmdq[i][0].mask;
      end
    end
  end

  task automatic push(input int r, input bit we, input bit [23:0] a, input bit [31:0] d, input bit [3:0] m);
    cmd_t t;
    t.we = we; t.addr = a; t.data = d; t.mask = m;
    cmdq[r].push_back(t);
  endtask

  task automatic wait_idle(input string tag, input int max);
    bit ok = 0;
    for (int k = 0; k < max && !ok; k++) begin
      @(negedge clk); #1;
      ok = (m_state == 0) && !core_busy && (drv_valid == '0) && (exp_q.size() == 0);
      for (int i = 0; i < NREQ; i++) if (cmdq[i].size() != 0) ok = 0;
    end
    chk(tag, ok, 1);
  endtask

  task automatic pulse_reset();
    @(negedge clk); #2 rst = 1'b1;
    @(negedge clk); @(negedge clk); #2 rst = 1'b0;
  endtask

  int exp2[6], exp5[4];
  int n_before, f_before;
  bit ok;

  initial begin
`ifdef SDRAM_ARB_PRIO0_EN
    exp2 = '{0, 0, 1, 2, 3, 1};
    exp5 = '{0, 0, 0, 3};
`else
    exp2 = '{0, 1, 2, 3, 0, 1};
    exp5 = '{0, 3, 0, 3};
`endif
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req_ready", bus.req_ready, '0);
    chk("rst_resp_valid", bus.resp_valid, '0);
    chk("rst_mem_valid", bus.mem_valid, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_addr", bus.mem_addr, '0);
    chk("rst_mem_wdata", bus.mem_wdata, '0);
    chk("rst_mem_wmask", bus.mem_wmask, '0);
    chk("rst_resp_rdata", bus.resp_rdata, '0);
    chk("rst_busy", busy, 0);
    @(negedge clk); #2 rst = 1'b0;

    // All four requesters continuously valid straight out of reset
    for (int r = 0; r < NREQ; r++) for (int k = 0; k < 2; k++) push(r, 0, 24'(16*r + k), 0, 0);
    wait_idle("t2_done", 400);
    for (int k = 0; k < 6; k++) chk("t2_order", grant_log[k], exp2[k]);

    // Single read
    grant_log.delete();
    core_mem[24'h000100] = 32'hDEADBEEF;
    ref_mem[24'h000100]  = 32'hDEADBEEF;
    push(0, 0, 24'h000100, 0, 0);
    wait_idle("t1_done", 100);
    chk("t1_owner", grant_log[0], 0);
    chk("t1_rdata", rdata_log[rdata_log.size() - 1], 32'hDEADBEEF);

    // Masked write held off by a stalling core, then read back
    grant_log.delete();
    stall_cfg = 5;
    push(2, 1, 24'h00ABCD, 32'h12345678, 4'h3);
    wait_idle("t3_done", 100);
    chk("t3_owner", grant_log[0], 2);
    chk("t3_hold_cycles", issue_hold, 5);
    stall_cfg = 0;
    push(1, 0, 24'h00ABCD, 0, 0);
    wait_idle("t3_rb_done", 100);
    chk("t3_readback", rdata_log[rdata_log.size() - 1], 32'h00005678);

    // Requesters 0 and 3 competing from a fresh reset
    pulse_reset();
    grant_log.delete();
    for (int k = 0; k < 3; k++) begin
      push(0, 0, 24'h000100, 0, 0);
      push(3, 0, 24'h000100, 0, 0);
    end
    wait_idle("t5_done", 300);
    for (int k = 0; k < 4; k++) chk("t5_order", grant_log[k], exp5[k]);

    // Reset while waiting for the core; the late completion must be dropped
    lat_cfg = 8;
    push(0, 0, 24'h000100, 0, 0);
    ok = 0;
    for (int k = 0; k < 50 && !ok; k++) begin @(negedge clk); #1; ok = (m_state == 2); end
    chk("t4_reach_wait", ok, 1);
    chk("t4_busy_before", busy, 1);
    n_before = rdata_log.size();
    f_before = resp_fired;
    @(negedge clk); #2 rst = 1'b1; #1;
    chk("t4_mem_valid", bus.mem_valid, 0);
    chk("t4_req_ready", bus.req_ready, '0);
    chk("t4_resp_valid", bus.resp_valid, '0);
    chk("t4_busy", busy, 0);
    chk("t4_mem_addr", bus.mem_addr, '0);
    chk("t4_resp_rdata", bus.resp_rdata, '0);
    @(negedge clk); @(negedge clk); #2 rst = 1'b0;
    ok = 0;
    for (int k = 0; k < 50 && !ok; k++) begin @(negedge clk); #1; ok = !core_busy; end
    @(negedge clk); @(negedge clk); #1;
    chk("t4_late_fired", resp_fired - f_before, 1);
    chk("t4_late_dropped", rdata_log.size(), n_before);
    lat_cfg = 0;
    grant_log.delete();
    push(1, 0, 24'h000004, 0, 0);
    push(0, 0, 24'h000008, 0, 0);
    wait_idle("t4_next_done", 100);
    chk("t4_first_after_rst", grant_log[0], 0);
    chk("t4_second_after_rst", grant_log[1], 1);

    // Random traffic with random core stall and latency
    grant_log.delete();
    stall_cfg = -1;
    lat_cfg = -1;
    for (int t = 0; t < 1000; t++) begin
      push(int'($urandom_range(0, NREQ - 1)), 1'($urandom_range(0, 1)),
           24'($urandom_range(0, 31)), $urandom, 4'($urandom_range(0, 15)));
      if (t % 4 == 3) repeat ($urandom_range(0, 12)) @(negedge clk);
    end
    wait_idle("t6_done", 30000);
    chk("t6_count", grant_log.size(), 1000);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
